// File: rtl/rv32i_pkg.sv
// Shared RV32I immediate definitions: immediate types, error codes and legal ranges.
// Also used by signextnd.
package rv32i_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_type_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_ALIGN = 2'd2,
      ERR_TYPE  = 2'd3
   } imm_err_e;

   localparam int signed IMM12_MIN = -2048;
   localparam int signed IMM12_MAX = 2047;
   localparam int signed IMM_B_MIN = -4096;
   localparam int signed IMM_B_MAX = 4094;
   localparam int signed IMM_J_MIN = -1048576;
   localparam int signed IMM_J_MAX = 1048574;

   function automatic logic imm_in_range(logic [31:0] v, int signed lo, int signed hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational: maps an immediate onto its instruction-word field positions for a type,
// and reports the highest-priority rule violation (type > align > range).
module imm_scatter
   import rv32i_pkg::*;
(
   input  logic [31:0] imm_i,
   input  logic [2:0]  type_i,
   output logic [31:0] mask_o,
   output logic [31:0] val_o,
   output imm_err_e    err_o
);

   imm_type_e typ;
   assign typ = imm_type_e'(type_i);

   always_comb begin
      mask_o = 32'h0;
      val_o  = 32'h0;
      err_o  = ERR_NONE;
      case (typ)
         IMM_I: begin
            mask_o = 32'hFFF0_0000;
            val_o  = {imm_i[11:0], 20'b0};
            if (!imm_in_range(imm_i, IMM12_MIN, IMM12_MAX)) err_o = ERR_RANGE;
         end
         IMM_S: begin
            mask_o = 32'hFE00_0F80;
            val_o  = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
            if (!imm_in_range(imm_i, IMM12_MIN, IMM12_MAX)) err_o = ERR_RANGE;
         end
         IMM_B: begin
            mask_o = 32'hFE00_0F80;
            val_o  = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
            if (imm_i[0])                                       err_o = ERR_ALIGN;
            else if (!imm_in_range(imm_i, IMM_B_MIN, IMM_B_MAX)) err_o = ERR_RANGE;
         end
         IMM_J: begin
            mask_o = 32'hFFFF_F000;
            val_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
            if (imm_i[0])                                       err_o = ERR_ALIGN;
            else if (!imm_in_range(imm_i, IMM_J_MIN, IMM_J_MAX)) err_o = ERR_RANGE;
         end
         IMM_U: begin
            // Low 12 bits must be zero: a U immediate is a full value, not a shifted one.
            mask_o = 32'hFFFF_F000;
            val_o  = {imm_i[31:12], 12'b0};
            if (imm_i[11:0] != 12'h0) err_o = ERR_ALIGN;
         end
         default: err_o = ERR_TYPE;
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// Immediate encoder: scatters a signed immediate into an instruction word, 2-cycle valid/ready pipe.
// Latency 2 cycles, throughput 1/cycle; in_ready drops same cycle when both stages are full and stalled.
module imm_packer
   import rv32i_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_imm,
   input  logic [2:0]           in_type,
   input  logic [31:0]          in_base,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [1:0]           out_err_code,
   input  logic                 clr_cnt,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic                 s1_valid_q;
   logic [31:0]          s1_mask_q, s1_val_q, s1_base_q;
   imm_err_e             s1_err_q;
   logic                 s2_valid_q;
   logic [31:0]          instr_q;
   logic                 err_q;
   imm_err_e             code_q;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] sc_mask, sc_val, instr_d;
   imm_err_e    sc_err;
   logic        s1_adv, s2_adv;

   imm_scatter u_scatter (
      .imm_i  (in_imm),
      .type_i (in_type),
      .mask_o (sc_mask),
      .val_o  (sc_val),
      .err_o  (sc_err)
   );

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // Errored requests pass the base word through untouched.
   assign instr_d = (s1_err_q != ERR_NONE) ? s1_base_q
                                           : ((s1_base_q & ~s1_mask_q) | s1_val_q);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt)
         cnt_d = '0;
      else if (s2_valid_q && out_ready && err_q && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mask_q  <= '0;
         s1_val_q   <= '0;
         s1_base_q  <= '0;
         s1_err_q   <= ERR_NONE;
         s2_valid_q <= 1'b0;
         instr_q    <= '0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
         cnt_q      <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_mask_q <= sc_mask;
               s1_val_q  <= sc_val;
               s1_base_q <= in_base;
               s1_err_q  <= sc_err;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               instr_q <= instr_d;
               err_q   <= (s1_err_q != ERR_NONE);
               code_q  <= s1_err_q;
            end
         end
         cnt_q <= cnt_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_instr    = instr_q;
   assign out_err      = err_q;
   assign out_err_code = code_q;
   assign err_cnt      = cnt_q;

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: directed vectors, backpressure, reset flush,
// counter saturation/clear and randomized legal round-trips.
module tb_imm_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_imm = '0;
   logic [2:0]  in_type = '0;
   logic [31:0] in_base = '0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [1:0]  out_err_code;
   logic        clr_cnt = 1'b0;
   logic [7:0]  err_cnt;

   logic        in_ready2, out_valid2, out_err2;
   logic [31:0] out_instr2;
   logic [1:0]  out_err_code2;
   logic [1:0]  err_cnt2;

   logic rdy_ctl = 1'b1;
   logic rand_rdy = 1'b0;
   logic rnd_bit = 1'b1;
   assign out_ready = rand_rdy ? rnd_bit : rdy_ctl;

   imm_packer #(.ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_type(in_type), .in_base(in_base),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .out_err_code(out_err_code), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
   );

   imm_packer #(.ERR_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_imm(in_imm), .in_type(in_type), .in_base(in_base),
      .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
      .out_err(out_err2), .out_err_code(out_err_code2), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [1:0]  code;
      logic [31:0] imm;
      logic [2:0]  t;
      int          acc;
      bit          strict;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   strict_lat = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: place immediate bits one at a time following the field tables.
   function automatic exp_t model(input logic [31:0] imm, input logic [2:0] t, input logic [31:0] base);
      exp_t   e;
      longint s;
      logic [31:0] r;
      s = longint'($signed(imm));
      r = base;
      e.code = 2'd0;
      if (t > 3'd4)
         e.code = 2'd3;
      else if (((t == 3'd2 || t == 3'd3) && imm[0]) || (t == 3'd4 && imm[11:0] != 12'h0))
         e.code = 2'd2;
      else if ((t <= 3'd1 && (s < -2048 || s > 2047)) ||
               (t == 3'd2 && (s < -4096 || s > 4094)) ||
               (t == 3'd3 && (s < -1048576 || s > 1048574)))
         e.code = 2'd1;
      if (e.code == 2'd0) begin
         case (t)
            3'd0: for (int i = 0; i < 12; i++) r[20+i] = imm[i];
            3'd1: begin
               for (int i = 0; i < 5; i++)  r[7+i]  = imm[i];
               for (int i = 5; i < 12; i++) r[20+i] = imm[i];
            end
            3'd2: begin
               r[31] = imm[12];
               r[7]  = imm[11];
               for (int i = 5; i < 11; i++) r[20+i] = imm[i];
               for (int i = 1; i < 5; i++)  r[7+i]  = imm[i];
            end
            3'd3: begin
               r[31] = imm[20];
               r[20] = imm[11];
               for (int i = 12; i < 20; i++) r[i]    = imm[i];
               for (int i = 1; i < 11; i++)  r[20+i] = imm[i];
            end
            default: for (int i = 12; i < 32; i++) r[i] = imm[i];
         endcase
      end
      e.instr = r;
      e.err   = (e.code != 2'd0);
      e.imm   = imm;
      e.t     = t;
      e.acc   = 0;
      e.strict = 1'b0;
      return e;
   endfunction

   // Sign extender: recovers the immediate from an encoded word.
   function automatic logic [31:0] sext(input logic [31:0] w, input logic [2:0] t);
      case (t)
         3'd0: return {{20{w[31]}}, w[31:20]};
         3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
         3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         3'd3: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: return {w[31:12], 12'h000};
      endcase
   endfunction

   task automatic push_cur(input bit use_k, input logic [31:0] k_instr, input logic [1:0] k_code);
      exp_t e;
      e = model(in_imm, in_type, in_base);
      if (use_k) begin
         e.instr = k_instr;
         e.code  = k_code;
         e.err   = (k_code != 2'd0);
      end
      e.acc    = cyc;
      e.strict = strict_lat;
      sb.push_back(e);
   endtask

   // Called right after a rising edge; returns right after the accepting edge.
   task automatic send(input logic [31:0] imm, input logic [2:0] t, input logic [31:0] base,
                       input bit use_k, input logic [31:0] k_instr, input logic [1:0] k_code);
      int n = 0;
      in_valid = 1'b1;
      in_imm   = imm;
      in_type  = t;
      in_base  = base;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      else push_cur(use_k, k_instr, k_code);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic sendm(input logic [31:0] imm, input logic [2:0] t, input logic [31:0] base);
      send(imm, t, base, 1'b0, 32'h0, 2'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: peek while stalled (checks stability), pop on transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb[0];
            chk("instr", out_instr, e.instr);
            chk("err", 32'(out_err), 32'(e.err));
            chk("err_code", 32'(out_err_code), 32'(e.code));
            if (out_ready) begin
               if (e.strict) chk("latency", 32'(cyc - e.acc), 32'd2);
               if (!e.err) chk("roundtrip", sext(out_instr, e.t), e.imm);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_code", 32'(out_err_code), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed legal vectors, no stalls.
      strict_lat = 1'b1;
      send(32'hFFFF_FF85, 3'd0, 32'h0000_0013, 1'b1, 32'hF850_0013, 2'd0);
      send(32'hFFFF_FFFC, 3'd2, 32'h0000_0063, 1'b1, 32'hFE00_0EE3, 2'd0);
      send(32'd2048,      3'd3, 32'h0000_006F, 1'b1, 32'h0010_006F, 2'd0);
      send(32'h1234_5000, 3'd4, 32'h0000_0037, 1'b1, 32'h1234_5037, 2'd0);
      // Range boundaries.
      sendm(32'd2047, 3'd0, 32'hA5A5_A5A5);
      sendm(-32'sd2048, 3'd1, 32'h5A5A_5A5A);
      sendm(-32'sd1, 3'd1, 32'h0000_0023);
      sendm(32'd4094, 3'd2, 32'hFFFF_FFFF);
      sendm(-32'sd4096, 3'd2, 32'h0000_0063);
      sendm(32'd1048574, 3'd3, 32'h0000_006F);
      sendm(-32'sd1048576, 3'd3, 32'h1234_5678);
      drain();

      // Errors: align, range, bad type.
      send(32'd3,    3'd2, 32'h0000_0063, 1'b1, 32'h0000_0063, 2'd2);
      send(32'd2048, 3'd0, 32'h0000_0013, 1'b1, 32'h0000_0013, 2'd1);
      send(32'd3,    3'd7, 32'h0000_0013, 1'b1, 32'h0000_0013, 2'd3);
      drain();
      chk("err_cnt_3", 32'(err_cnt), 32'd3);
      chk("err_cnt2_3", 32'(err_cnt2), 32'd3);
      sendm(32'd4096, 3'd2, 32'h0000_0063);
      sendm(32'h0000_0123, 3'd4, 32'h0000_0037);
      drain();
      chk("err_cnt_5", 32'(err_cnt), 32'd5);
      chk("err_cnt2_sat", 32'(err_cnt2), 32'd3);

      // Clear collides with an errored transfer.
      rdy_ctl = 1'b0;
      strict_lat = 1'b0;
      sendm(32'd1, 3'd3, 32'h0000_006F);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("clr_wait_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      rdy_ctl = 1'b1;
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      @(negedge clk);
      chk("clr_wins", 32'(err_cnt), 32'd0);
      chk("clr_wins2", 32'(err_cnt2), 32'd0);
      drain();

      // Backpressure: third request sees a full pipe.
      rdy_ctl = 1'b0;
      in_valid = 1'b1; in_imm = 32'd100; in_type = 3'd0; in_base = 32'h0000_0013;
      @(negedge clk);
      chk("bp_acc_a", 32'(in_ready), 32'd1);
      if (in_ready) push_cur(1'b0, 32'h0, 2'd0);
      @(posedge clk); #1;
      in_imm = -32'sd8; in_type = 3'd1; in_base = 32'h0000_0023;
      @(negedge clk);
      chk("bp_acc_b", 32'(in_ready), 32'd1);
      if (in_ready) push_cur(1'b0, 32'h0, 2'd0);
      @(posedge clk); #1;
      in_imm = 32'd7; in_type = 3'd2; in_base = 32'h0000_0063;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_full", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      rdy_ctl = 1'b1;
      @(negedge clk);
      chk("bp_both", 32'(in_ready), 32'd1);
      if (in_ready) push_cur(1'b0, 32'h0, 2'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Reset with two requests in flight.
      rdy_ctl = 1'b0;
      sendm(32'd5, 3'd0, 32'h0000_0013);
      sendm(32'd6, 3'd0, 32'h0000_0013);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("rst_flush_valid", 32'(out_valid), 32'd0);
      chk("rst_flush_ready", 32'(in_ready), 32'd1);
      rdy_ctl = 1'b1;
      repeat (10) @(negedge clk);
      @(posedge clk); #1;

      // Random legal round-trips under random backpressure.
      rand_rdy = 1'b1;
      for (int t = 0; t < 5; t++) begin
         for (int k = 0; k < 500; k++) begin
            logic [31:0] v;
            case (t)
               0, 1:    v = 32'($urandom_range(0, 4095)) - 32'd2048;
               2:       v = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
               3:       v = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
               default: v = $urandom & 32'hFFFF_F000;
            endcase
            sendm(v, 3'(t), $urandom);
         end
      end
      drain();
      rand_rdy = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
